// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW scoreboard, redirect flush and retire-valid pipe for a non-forwarding 5-stage pipeline
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int WB_DIST  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_id_vld,
    input  logic [4:0]          i_id_rs1_addr,
    input  logic [4:0]          i_id_rs2_addr,
    input  logic                i_id_rs1_used,
    input  logic                i_id_rs2_used,
    input  logic [4:0]          i_id_rd_addr,
    input  logic                i_id_rd_wren,
    input  logic                i_ex_redirect,
    output logic                o_stall,
    output logic                o_issue,
    output logic                o_flush_ifid,
    output logic                o_flush_idex,
    output logic                o_wb_vld,
    output logic [NUM_REGS-1:0] o_busy_vec,
    output logic [31:0]         o_stall_cnt
);

    localparam int CW = (WB_DIST < 2) ? 1 : $clog2(WB_DIST + 1);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [31:0]         busy_ext;
    logic                hz;
    logic                set_en;
    logic                vex;
    logic                vmem;
    logic                vwb;

    // x0 is hardwired zero, so its entry never reports busy
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        busy_ext = '0;
        busy_ext[NUM_REGS-1:0] = busy;
    end

    assign hz = i_id_vld &
                ((i_id_rs1_used & (i_id_rs1_addr != 5'd0) & busy_ext[i_id_rs1_addr]) |
                 (i_id_rs2_used & (i_id_rs2_addr != 5'd0) & busy_ext[i_id_rs2_addr]));

    // A redirect kills the ID instruction, so it neither stalls nor issues
    assign o_flush_ifid = i_ex_redirect;
    assign o_flush_idex = i_ex_redirect | hz;
    assign o_stall      = hz & ~i_ex_redirect;
    assign o_issue      = i_id_vld & ~hz & ~i_ex_redirect;

    assign set_en = o_issue & i_id_rd_wren & (i_id_rd_addr != 5'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (set_en && (i_id_rd_addr == 5'(r))) begin
                    cnt[r] <= CW'(WB_DIST);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vex         <= 1'b0;
            vmem        <= 1'b0;
            vwb         <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            vex  <= o_issue;
            vmem <= vex;
            vwb  <= vmem;
            if (o_stall && (o_stall_cnt != 32'hFFFF_FFFF)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end

    assign o_wb_vld   = vwb;
    assign o_busy_vec = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench for hazard_scoreboard with a ready-cycle reference model
module tb_hazard_scoreboard;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_id_vld;
    logic [4:0]  i_id_rs1_addr;
    logic [4:0]  i_id_rs2_addr;
    logic        i_id_rs1_used;
    logic        i_id_rs2_used;
    logic [4:0]  i_id_rd_addr;
    logic        i_id_rd_wren;
    logic        i_ex_redirect;
    logic        o_stall;
    logic        o_issue;
    logic        o_flush_ifid;
    logic        o_flush_idex;
    logic        o_wb_vld;
    logic [31:0] o_busy_vec;
    logic [31:0] o_stall_cnt;

    hazard_scoreboard #(.NUM_REGS(32), .WB_DIST(3)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_id_vld      (i_id_vld),
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_id_rd_addr  (i_id_rd_addr),
        .i_id_rd_wren  (i_id_rd_wren),
        .i_ex_redirect (i_ex_redirect),
        .o_stall       (o_stall),
        .o_issue       (o_issue),
        .o_flush_ifid  (o_flush_ifid),
        .o_flush_idex  (o_flush_idex),
        .o_wb_vld      (o_wb_vld),
        .o_busy_vec    (o_busy_vec),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   ready_at [32];
    int   retire_q [$];
    int   stall_model;
    logic pend_issue;
    logic pend_stall;
    logic pend_wren;
    logic [4:0] pend_rd;
    logic rst_next;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%h, required 0x%h", name, cyc, act, exp);
        end
    endtask

    // Register r is busy while the current cycle is before the cycle its last writer's value becomes readable
    task automatic check_model();
        logic [31:0] bm;
        logic        hz;
        logic        e_stall;
        logic        e_issue;
        logic        e_wb;
        if (!i_rst_n) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            retire_q.delete();
            stall_model = 0;
        end
        bm = '0;
        for (int r = 1; r < 32; r++) bm[r] = (cyc < ready_at[r]);
        hz = i_id_vld && ((i_id_rs1_used && i_id_rs1_addr != 0 && bm[i_id_rs1_addr]) ||
                          (i_id_rs2_used && i_id_rs2_addr != 0 && bm[i_id_rs2_addr]));
        e_stall = hz && !i_ex_redirect;
        e_issue = i_id_vld && !hz && !i_ex_redirect;
        e_wb = 1'b0;
        foreach (retire_q[i]) if (retire_q[i] == cyc - 3) e_wb = 1'b1;
        cmp("m_busy_vec",   o_busy_vec, bm);
        cmp("m_stall",      32'(o_stall), 32'(e_stall));
        cmp("m_issue",      32'(o_issue), 32'(e_issue));
        cmp("m_flush_ifid", 32'(o_flush_ifid), 32'(i_ex_redirect));
        cmp("m_flush_idex", 32'(o_flush_idex), 32'(i_ex_redirect || hz));
        cmp("m_wb_vld",     32'(o_wb_vld), 32'(e_wb));
        cmp("m_stall_cnt",  o_stall_cnt, 32'(stall_model));
        pend_issue = e_issue && i_rst_n;
        pend_stall = e_stall && i_rst_n;
        pend_wren  = i_id_rd_wren;
        pend_rd    = i_id_rd_addr;
    endtask

    task automatic commit_model();
        if (i_rst_n) begin
            if (pend_issue) begin
                retire_q.push_back(cyc);
                if (pend_wren && pend_rd != 0) ready_at[pend_rd] = cyc + 4;
            end
            if (pend_stall) stall_model++;
        end
        cyc++;
    endtask

    task automatic drive(input logic vld, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wren, input logic redir);
        @(posedge i_clk);
        commit_model();
        #1;
        i_rst_n       = rst_next;
        i_id_vld      = vld;
        i_id_rs1_addr = rs1;
        i_id_rs1_used = u1;
        i_id_rs2_addr = rs2;
        i_id_rs2_used = u2;
        i_id_rd_addr  = rd;
        i_id_rd_wren  = wren;
        i_ex_redirect = redir;
        @(negedge i_clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic prod(input logic [4:0] rd);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0);
    endtask

    task automatic cons(input logic [4:0] rs1);
        drive(1'b1, rs1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; stall_model = 0;
        pend_issue = 0; pend_stall = 0; pend_wren = 0; pend_rd = '0;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        rst_next = 1'b0;
        i_rst_n = 1'b0; i_id_vld = 1'b0; i_id_rs1_addr = '0; i_id_rs2_addr = '0;
        i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0; i_id_rd_addr = '0;
        i_id_rd_wren = 1'b0; i_ex_redirect = 1'b0;

        // reset held with a valid instruction reading x5
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("rst_busy", o_busy_vec, 32'h0);
        cmp("rst_stall", 32'(o_stall), 32'd0);
        cmp("rst_issue", 32'(o_issue), 32'd1);
        cmp("rst_stall_cnt", o_stall_cnt, 32'd0);
        rst_next = 1'b1;
        idle(2);

        // RAW: producer x5 at c0, consumer waits c1..c3, issues c4
        prod(5'd5);
        cons(5'd5);
        cmp("raw_stall_c1", 32'(o_stall), 32'd1);
        cmp("raw_idex_c1", 32'(o_flush_idex), 32'd1);
        cons(5'd5);
        cmp("raw_stall_c2", 32'(o_stall), 32'd1);
        cons(5'd5);
        cmp("raw_stall_c3", 32'(o_stall), 32'd1);
        cmp("raw_wb_c3", 32'(o_wb_vld), 32'd1);
        cons(5'd5);
        cmp("raw_issue_c4", 32'(o_issue), 32'd1);
        cmp("raw_stall_cnt", o_stall_cnt, 32'd3);
        idle(4);

        // x0 never tracked; unused rs2 ignored
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        cmp("x0_stall", 32'(o_stall), 32'd0);
        cmp("x0_busy", o_busy_vec, 32'h0);
        prod(5'd9);
        drive(1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("unused_stall", 32'(o_stall), 32'd0);
        cmp("unused_issue", 32'(o_issue), 32'd1);
        cmp("unused_busy", o_busy_vec, 32'h0000_0200);
        idle(4);

        // redirect in a hazard cycle: flush, no stall, no new entry for x11
        prod(5'd10);
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        cmp("redir_ifid", 32'(o_flush_ifid), 32'd1);
        cmp("redir_idex", 32'(o_flush_idex), 32'd1);
        cmp("redir_stall", 32'(o_stall), 32'd0);
        cmp("redir_issue", 32'(o_issue), 32'd0);
        idle(1);
        cmp("redir_stall_cnt", o_stall_cnt, 32'd3);
        cmp("redir_busy", o_busy_vec, 32'h0000_0400);
        idle(3);

        // WAW: x7 at c0 and c2, busy through c5
        prod(5'd7);
        idle(1);
        prod(5'd7);
        idle(3);
        cmp("waw_busy_c5", 32'(o_busy_vec[7]), 32'd1);
        idle(1);
        cmp("waw_busy_c6", 32'(o_busy_vec[7]), 32'd0);
        idle(2);

        // back-to-back independent issue into x1..x4
        prod(5'd1);
        prod(5'd2);
        prod(5'd3);
        prod(5'd4);
        cmp("b2b_busy_c3", o_busy_vec, 32'h0000_000E);
        cmp("b2b_wb_c3", 32'(o_wb_vld), 32'd1);
        idle(1);
        cmp("b2b_busy_c4", o_busy_vec, 32'h0000_001C);
        cmp("b2b_wb_c4", 32'(o_wb_vld), 32'd1);
        idle(1);
        cmp("b2b_wb_c5", 32'(o_wb_vld), 32'd1);
        idle(1);
        cmp("b2b_wb_c6", 32'(o_wb_vld), 32'd1);
        cmp("b2b_busy_c6", o_busy_vec, 32'h0000_0010);
        idle(1);
        cmp("b2b_wb_c7", 32'(o_wb_vld), 32'd0);
        cmp("b2b_stall_cnt", o_stall_cnt, 32'd3);

        // reset mid-operation discards the pending x12 write
        prod(5'd12);
        rst_next = 1'b0;
        idle(1);
        cmp("midrst_busy", o_busy_vec, 32'h0);
        cmp("midrst_stall_cnt", o_stall_cnt, 32'd0);
        rst_next = 1'b1;
        idle(1);
        prod(5'd13);
        idle(1);
        cmp("postrst_busy", o_busy_vec, 32'h0000_2000);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
